// File: rtl/audio_stream_framer_if.sv
// Byte-stream-in / frame-out bundle between rxuart, the framer and the per-channel DACs.
// slave = framer side, master = source/monitor side.
interface audio_stream_framer_if #(
  parameter int BITS     = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16
);
  logic [7:0]               rx_byte;
  logic                     rx_valid;
  logic                     err_clr;
  logic [CHANNELS*BITS-1:0] sample_out;
  logic                     sample_ce;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     overflow;
  logic                     underrun;
  logic                     resync;

  modport slave (
    input  rx_byte, rx_valid, err_clr,
    output sample_out, sample_ce, fifo_level, overflow, underrun, resync
  );

  modport master (
    output rx_byte, rx_valid, err_clr,
    input  sample_out, sample_ce, fifo_level, overflow, underrun, resync
  );
endinterface

// File: rtl/audio_stream_framer.sv
// audio_stream_framer: LE interleaved rxuart bytes -> frames -> FIFO -> one frame per RATE_DIV tick.
// Latency: frame readable the cycle after its last byte; sample_out/sample_ce update the cycle after a tick.
// No backpressure: frames hitting a full FIFO are dropped (overflow). AUDIO_RESYNC_EN adds idle resync.
module audio_stream_framer #(
  parameter int BITS          = 16,
  parameter int CHANNELS      = 2,
  parameter int DEPTH         = 16,
  parameter int RATE_DIV      = 250,
  parameter int UNDERRUN_HOLD = 1,
  parameter int TIMEOUT       = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  audio_stream_framer_if.slave bus
);
  localparam int FW = CHANNELS * BITS;
  localparam int NB = BITS / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [BITS-1:0] MID_CH   = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [FW-1:0]   MIDSCALE = {CHANNELS{MID_CH}};

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [BW-1:0] byte_idx, byte_eff;
  logic [CW-1:0] ch_idx, ch_eff;
  logic [FW-1:0] frame_q, frame_next;
  logic          timeout_fire;
  logic          last_byte, push;

`ifdef AUDIO_RESYNC_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  logic          resync_q;

  assign timeout_fire = (idle_cnt == IW'(TIMEOUT)) && ((byte_idx != '0) || (ch_idx != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      resync_q <= 1'b0;
    end else begin
      if (bus.rx_valid)                 idle_cnt <= '0;
      else if (idle_cnt != IW'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
      resync_q <= timeout_fire;
    end
  end

  // A byte landing on the timeout cycle starts the new frame.
  assign byte_eff   = timeout_fire ? '0 : byte_idx;
  assign ch_eff     = timeout_fire ? '0 : ch_idx;
  assign bus.resync = resync_q;
`else
  assign timeout_fire = 1'b0;
  assign byte_eff     = byte_idx;
  assign ch_eff       = ch_idx;
  assign bus.resync   = 1'b0;
`endif

  always_comb begin
    frame_next = frame_q;
    frame_next[(int'(ch_eff) * NB + int'(byte_eff)) * 8 +: 8] = bus.rx_byte;
  end

  assign last_byte = (byte_eff == BW'(NB - 1)) && (ch_eff == CW'(CHANNELS - 1));
  assign push      = bus.rx_valid && last_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      ch_idx   <= '0;
      frame_q  <= '0;
    end else if (bus.rx_valid) begin
      frame_q <= frame_next;
      if (byte_eff == BW'(NB - 1)) begin
        byte_idx <= '0;
        ch_idx   <= (ch_eff == CW'(CHANNELS - 1)) ? '0 : ch_eff + 1'b1;
      end else begin
        byte_idx <= byte_eff + 1'b1;
      end
    end else if (timeout_fire) begin
      byte_idx <= '0;
      ch_idx   <= '0;
    end
  end

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= TW'(RATE_DIV - 1);
    else if (tick) tick_cnt <= TW'(RATE_DIV - 1);
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // Extra pointer MSB separates full from empty.
  logic [FW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, level_q;
  logic          empty, full, pop, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = tick && !empty;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= frame_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  logic [FW-1:0] sample_q;
  logic          ce_q, ovf_q, und_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      ce_q     <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      ce_q <= tick;
      if (pop)                              sample_q <= mem[rd_ptr[AW-1:0]];
      else if (tick && UNDERRUN_HOLD == 0)  sample_q <= MIDSCALE;
      if (tick && empty)     und_q <= 1'b1;
      else if (bus.err_clr)  und_q <= 1'b0;
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (bus.err_clr)     ovf_q <= 1'b0;
    end
  end

  assign bus.sample_out = sample_q;
  assign bus.sample_ce  = ce_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = ovf_q;
  assign bus.underrun   = und_q;
endmodule
